// File: rtl/pwm_duty_generator.sv
// rtl/pwm_duty_generator.sv - fixed-frequency PWM with button-stepped duty cycle
// Optional feature macro: PWM_GLITCHFREE_UPDATE_EN (duty changes applied only at period start)

module pwm_button_debounce (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic btn_i,
    output logic press_o
);
    logic s1_q;
    logic s2_q;
    logic db_q;
    logic db;

    // The button must be seen high on two consecutive ticks to register.
    assign db      = s1_q & s2_q;
    assign press_o = db & ~db_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            db_q <= 1'b0;
        end else begin
            if (tick_i) begin
                s1_q <= btn_i;
                s2_q <= s1_q;
            end
            db_q <= db;
        end
    end
endmodule

module pwm_duty_generator #(
    parameter int PERIOD    = 10,
    parameter int DUTY_INIT = 5,
    parameter int DUTY_MIN  = 1,
    parameter int DUTY_MAX  = 9,
    parameter int DEB_DIV   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic increase_duty,
    input  logic decrease_duty,
    output logic PWM_OUT
);
    localparam int W  = $clog2(PERIOD + 1);
    localparam int DW = $clog2(DEB_DIV + 1);

    localparam logic [W-1:0]  CNT_LAST   = W'(PERIOD - 1);
    localparam logic [W-1:0]  DUTY_RST   = W'(DUTY_INIT);
    localparam logic [W-1:0]  DUTY_LO    = W'(DUTY_MIN);
    localparam logic [W-1:0]  DUTY_HI    = W'(DUTY_MAX);
    localparam logic [DW-1:0] DIV_LAST   = DW'(DEB_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  duty_q, duty_d;
    logic [W-1:0]  active_duty;
    logic          pwm_q, pwm_d;
    logic          inc_press;
    logic          dec_press;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + 1'b1;
        if (tick) begin
            div_d = '0;
        end
    end

    pwm_button_debounce u_inc_btn (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (tick),
        .btn_i   (increase_duty),
        .press_o (inc_press)
    );

    pwm_button_debounce u_dec_btn (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (tick),
        .btn_i   (decrease_duty),
        .press_o (dec_press)
    );

    // Simultaneous presses cancel; limits saturate rather than wrap.
    always_comb begin
        duty_d = duty_q;
        if (inc_press && !dec_press && (duty_q < DUTY_HI)) begin
            duty_d = duty_q + 1'b1;
        end else if (dec_press && !inc_press && (duty_q > DUTY_LO)) begin
            duty_d = duty_q - 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    assign pwm_d = (cnt_q < active_duty);

`ifdef PWM_GLITCHFREE_UPDATE_EN
    logic [W-1:0] active_duty_q;

    assign active_duty = active_duty_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_duty_q <= DUTY_RST;
        end else if (cnt_q == CNT_LAST) begin
            active_duty_q <= duty_q;
        end
    end
`else
    assign active_duty = duty_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            cnt_q  <= '0;
            duty_q <= DUTY_RST;
            pwm_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign PWM_OUT = pwm_q;
endmodule

// File: tb/tb_pwm_duty_generator.sv
// tb/tb_pwm_duty_generator.sv - directed self-checking bench for pwm_duty_generator

module tb_pwm_duty_generator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic increase_duty = 1'b0;
    logic decrease_duty = 1'b0;
    logic PWM_OUT;

    int compared   = 0;
    int mismatched = 0;

    pwm_duty_generator dut (
        .clk           (clk),
        .rst           (rst),
        .increase_duty (increase_duty),
        .decrease_duty (decrease_duty),
        .PWM_OUT       (PWM_OUT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Any 20-cycle window of a period-10 waveform holds exactly 2*duty high cycles.
    task automatic check_duty(input string tag, input int duty);
        int highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            highs += int'(PWM_OUT);
        end
        check(tag, highs, 2 * duty);
    endtask

    task automatic check_first_period(input string tag);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, k), int'(PWM_OUT), (k <= 5) ? 1 : 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press(input bit inc, input bit dec);
        @(negedge clk);
        increase_duty = inc;
        decrease_duty = dec;
        repeat (10) @(negedge clk);
        increase_duty = 1'b0;
        decrease_duty = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        // 1: reset state, then 5 high / 5 low from cnt = 0
        repeat (2) @(negedge clk);
        check("reset_pwm_low", int'(PWM_OUT), 0);
        rst = 1'b0;
        check_first_period("init_period");
        check_duty("init_duty5", 5);

        // 2: one 10-cycle press gives exactly one step
        press(1'b1, 1'b0);
        check_duty("single_inc_duty6", 6);
        repeat (40) @(negedge clk);
        check_duty("held_once_duty6", 6);

        // 3: 5->6->7->8->7->6->5
        do_reset();
        press(1'b1, 1'b0); check_duty("seq_inc1_6", 6);
        press(1'b1, 1'b0); check_duty("seq_inc2_7", 7);
        press(1'b1, 1'b0); check_duty("seq_inc3_8", 8);
        press(1'b0, 1'b1); check_duty("seq_dec1_7", 7);
        press(1'b0, 1'b1); check_duty("seq_dec2_6", 6);
        press(1'b0, 1'b1); check_duty("seq_dec3_5", 5);

        // 4: saturation at both ends
        do_reset();
        for (int i = 0; i < 7; i++) press(1'b1, 1'b0);
        check_duty("sat_max_9", 9);
        for (int i = 0; i < 9; i++) press(1'b0, 1'b1);
        check_duty("sat_min_1", 1);

        // 5: one-cycle glitch and simultaneous presses leave duty alone
        do_reset();
        for (int i = 0; i < 4; i++) begin
            repeat (i + 3) @(negedge clk);
            increase_duty = 1'b1;
            @(negedge clk);
            increase_duty = 1'b0;
        end
        repeat (20) @(negedge clk);
        check_duty("glitch_duty5", 5);
        press(1'b1, 1'b1);
        check_duty("both_duty5", 5);

        // 6: reset mid-period at duty 8
        do_reset();
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
        check_duty("pre_rst_duty8", 8);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("midrst_async_low", int'(PWM_OUT), 0);
        @(negedge clk);
        @(negedge clk);
        check("midrst_held_low", int'(PWM_OUT), 0);
        rst = 1'b0;
        check_first_period("post_rst");
        check_duty("post_rst_duty5", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
